// File: rtl/freelist_ckpt_pkg.sv
// Shared defaults, derived widths and packet types for the checkpointed free list.
package freelist_ckpt_pkg;

    localparam int FL_N_PREG = 64;
    localparam int FL_N_AREG = 32;
    localparam int FL_WAYS   = 2;
    localparam int FL_N_CKPT = 4;
    localparam int FL_PW     = $clog2(FL_N_PREG);
    localparam int FL_CW     = $clog2(FL_N_CKPT);

    // Dispatch request: one bit per way.
    typedef struct packed {
        logic [FL_WAYS-1:0] req;
    } FL_ALLOC_REQ;

    // Dispatch response: per-way grant and granted index (0 when not granted).
    typedef struct packed {
        logic [FL_WAYS-1:0]       valid;
        logic [FL_WAYS*FL_PW-1:0] idx;
    } FL_ALLOC_RESP;

    // One retire lane: the previous mapping (Told) being returned.
    typedef struct packed {
        logic             valid;
        logic [FL_PW-1:0] told_idx;
    } FL_RETIRE;

    // Mispredict recovery command.
    typedef struct packed {
        logic                 en;
        logic [FL_CW-1:0]     id;
        logic [FL_N_CKPT-1:0] kill;
    } FL_RECOVER;

    // Width of a counter able to hold 0..n inclusive.
    function automatic int fl_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fl_pick_lowest.sv
// Lowest-set-bit priority selector: one-hot grant of the lowest 1 in vec.
module fl_pick_lowest #(
    parameter int W = 64
) (
    input  logic [W-1:0] vec,
    output logic [W-1:0] grant,
    output logic         found
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        grant = vec & (~vec + W'(1));
        found = |vec;
    end

endmodule

// File: rtl/freelist_ckpt.sv
// Multi-way physical register free list with per-branch checkpoints.
// Allocation and the retire bypass are combinational; state, slot-valid
// vector and free count are registered. Recovery restores in one cycle.
module freelist_ckpt
    import freelist_ckpt_pkg::*;
#(
    parameter int N_PREG = FL_N_PREG,
    parameter int N_AREG = FL_N_AREG,
    parameter int WAYS   = FL_WAYS,
    parameter int N_CKPT = FL_N_CKPT,
    localparam int PW    = $clog2(N_PREG),
    localparam int CW    = $clog2(N_CKPT),
    localparam int CNT_W = fl_cnt_width(N_PREG)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WAYS-1:0]      alloc_req,
    output logic [WAYS-1:0]      alloc_valid,
    output logic [WAYS*PW-1:0]   alloc_idx,
    input  logic [WAYS-1:0]      retire_valid,
    input  logic [WAYS*PW-1:0]   retire_idx,
    input  logic                 ckpt_take,
    input  logic [CW-1:0]        ckpt_take_id,
    input  logic                 ckpt_release,
    input  logic [CW-1:0]        ckpt_release_id,
    input  logic                 recover,
    input  logic [CW-1:0]        recover_id,
    input  logic [N_CKPT-1:0]    recover_kill,
    output logic [N_CKPT-1:0]    ckpt_valid,
    output logic [CNT_W-1:0]     free_count
);

    logic [N_PREG-1:0] freelist;
    logic [N_PREG-1:0] snap  [N_CKPT];
    logic [N_PREG-1:0] freed [N_CKPT];

    logic [N_PREG-1:0]          retire_mask;
    logic [N_PREG-1:0]          avail;
    logic [N_PREG-1:0]          grant_all;
    logic [N_PREG-1:0]          next_fl;
    logic [WAYS:0][N_PREG-1:0]  residual;
    logic [WAYS-1:0][N_PREG-1:0] pick;
    logic [WAYS-1:0]            found;
    logic [WAYS-1:0]            grant_way;
    logic [N_CKPT-1:0]          next_valid;
    logic [CNT_W-1:0]           next_count;
    logic                       take_en;

    // Decode the retiring Told indices into a bit mask.
    always_comb begin
        retire_mask = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (retire_valid[w]) begin
                retire_mask[retire_idx[w*PW +: PW]] = 1'b1;
            end
        end
    end

    // Retired registers are allocatable in the same cycle.
    assign avail       = freelist | retire_mask;
    assign residual[0] = avail;

    // Chain of selectors: each requesting way takes the lowest remaining bit,
    // non-requesting ways pass the residual through untouched.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        fl_pick_lowest #(.W(N_PREG)) u_pick (
            .vec   (residual[w]),
            .grant (pick[w]),
            .found (found[w])
        );
        assign grant_way[w]  = alloc_req[w] & found[w] & ~recover & ~reset;
        assign residual[w+1] = grant_way[w] ? (residual[w] & ~pick[w]) : residual[w];
    end

    assign alloc_valid = grant_way;

    // Encode one-hot grants to indices and collect all consumed bits.
    always_comb begin
        alloc_idx = '0;
        grant_all = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (grant_way[w]) begin
                grant_all = grant_all | pick[w];
                for (int i = 0; i < N_PREG; i++) begin
                    if (pick[w][i]) begin
                        alloc_idx[w*PW +: PW] = PW'(i);
                    end
                end
            end
        end
    end

    // Next free list: restored image on recover, otherwise avail minus grants.
    always_comb begin
        if (recover) begin
            next_fl = snap[recover_id] | freed[recover_id] | retire_mask;
        end else begin
            next_fl = avail & ~grant_all;
        end
    end

    // Popcount of the next free list feeds the registered free count.
    always_comb begin
        next_count = '0;
        for (int i = 0; i < N_PREG; i++) begin
            next_count = next_count + CNT_W'(next_fl[i]);
        end
    end

    // Slot-valid update: release, then recover kills, then take (take wins).
    always_comb begin
        take_en    = ckpt_take & ~recover;
        next_valid = ckpt_valid;
        if (ckpt_release) begin
            next_valid[ckpt_release_id] = 1'b0;
        end
        if (recover) begin
            next_valid = next_valid & ~recover_kill & ~(N_CKPT'(1) << recover_id);
        end
        if (take_en) begin
            next_valid[ckpt_take_id] = 1'b1;
        end
    end

    // State registers: free list, checkpoints, retire-since-snapshot masks.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_PREG; i++) begin
                freelist[i] <= (i >= N_AREG);
            end
            for (int s = 0; s < N_CKPT; s++) begin
                snap[s]  <= '0;
                freed[s] <= '0;
            end
            ckpt_valid <= '0;
            free_count <= CNT_W'(N_PREG - N_AREG);
        end else begin
            freelist   <= next_fl;
            free_count <= next_count;
            ckpt_valid <= next_valid;
            for (int s = 0; s < N_CKPT; s++) begin
                if (take_en && (ckpt_take_id == CW'(s))) begin
                    snap[s]  <= next_fl;
                    freed[s] <= '0;
                end else if (ckpt_valid[s]) begin
                    freed[s] <= freed[s] | retire_mask;
                end
            end
        end
    end

    // Recovering from a slot that holds no checkpoint is illegal.
    a_recover_valid: assert property (@(posedge clock) disable iff (reset)
        recover |-> ckpt_valid[recover_id]);

    for (genvar a = 0; a < WAYS; a++) begin : g_chk
        // A retired register must not already be on the free list.
        a_retire_not_free: assert property (@(posedge clock) disable iff (reset)
            retire_valid[a] |-> !freelist[retire_idx[a*PW +: PW]]);
        for (genvar b = a + 1; b < WAYS; b++) begin : g_pair
            // Two ways never retire the same register in one cycle.
            a_retire_unique: assert property (@(posedge clock) disable iff (reset)
                (retire_valid[a] && retire_valid[b]) |->
                (retire_idx[a*PW +: PW] != retire_idx[b*PW +: PW]));
            // Two ways never receive the same register.
            a_alloc_unique: assert property (@(posedge clock) disable iff (reset)
                (alloc_valid[a] && alloc_valid[b]) |->
                (alloc_idx[a*PW +: PW] != alloc_idx[b*PW +: PW]));
        end
    end

endmodule

// File: tb/tb_freelist_ckpt.sv
// Self-checking bench for freelist_ckpt: directed scenarios plus a random run
// compared against a set-based reference model.
module tb_freelist_ckpt;
    import freelist_ckpt_pkg::*;

    localparam int N_PREG = 64;
    localparam int N_AREG = 32;
    localparam int WAYS   = 2;
    localparam int N_CKPT = 4;
    localparam int PW     = 6;
    localparam int CW     = 2;
    localparam int CNT_W  = 7;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [WAYS-1:0]    alloc_req;
    logic [WAYS-1:0]    alloc_valid;
    logic [WAYS*PW-1:0] alloc_idx;
    logic [WAYS-1:0]    retire_valid;
    logic [WAYS*PW-1:0] retire_idx;
    logic               ckpt_take;
    logic [CW-1:0]      ckpt_take_id;
    logic               ckpt_release;
    logic [CW-1:0]      ckpt_release_id;
    logic               recover;
    logic [CW-1:0]      recover_id;
    logic [N_CKPT-1:0]  recover_kill;
    logic [N_CKPT-1:0]  ckpt_valid;
    logic [CNT_W-1:0]   free_count;

    freelist_ckpt dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_valid     (alloc_valid),
        .alloc_idx       (alloc_idx),
        .retire_valid    (retire_valid),
        .retire_idx      (retire_idx),
        .ckpt_take       (ckpt_take),
        .ckpt_take_id    (ckpt_take_id),
        .ckpt_release    (ckpt_release),
        .ckpt_release_id (ckpt_release_id),
        .recover         (recover),
        .recover_id      (recover_id),
        .recover_kill    (recover_kill),
        .ckpt_valid      (ckpt_valid),
        .free_count      (free_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: sets of register numbers
    bit m_free  [N_PREG];
    bit m_snap  [N_CKPT][N_PREG];
    bit m_freed [N_CKPT][N_PREG];
    bit m_valid [N_CKPT];
    bit m_rm    [N_PREG];
    bit m_gnt   [N_PREG];
    int m_count;
    logic [WAYS-1:0]    exp_valid;
    logic [WAYS*PW-1:0] exp_idx;
    logic [N_CKPT-1:0]  exp_ckv;

    task automatic model_reset();
        for (int i = 0; i < N_PREG; i++) m_free[i] = (i >= N_AREG);
        for (int s = 0; s < N_CKPT; s++) begin
            m_valid[s] = 0;
            for (int i = 0; i < N_PREG; i++) begin
                m_snap[s][i] = 0;
                m_freed[s][i] = 0;
            end
        end
        m_count = N_PREG - N_AREG;
    endtask

    // Expected grants from current inputs: k-th requester takes k-th lowest free.
    task automatic model_eval();
        int q[$];
        for (int i = 0; i < N_PREG; i++) begin
            m_rm[i] = 0;
            m_gnt[i] = 0;
        end
        for (int w = 0; w < WAYS; w++)
            if (retire_valid[w]) m_rm[int'(retire_idx[w*PW +: PW])] = 1;
        exp_valid = '0;
        exp_idx   = '0;
        if (!reset && !recover) begin
            for (int i = 0; i < N_PREG; i++)
                if (m_free[i] || m_rm[i]) q.push_back(i);
            for (int w = 0; w < WAYS; w++) begin
                if (alloc_req[w] && q.size() > 0) begin
                    int g;
                    g = q.pop_front();
                    exp_valid[w] = 1'b1;
                    exp_idx[w*PW +: PW] = PW'(g);
                    m_gnt[g] = 1;
                end
            end
        end
    endtask

    task automatic model_commit();
        bit nf[N_PREG];
        bit take;
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < N_PREG; i++) begin
                if (recover)
                    nf[i] = m_snap[recover_id][i] | m_freed[recover_id][i] | m_rm[i];
                else
                    nf[i] = (m_free[i] | m_rm[i]) & !m_gnt[i];
            end
            take = ckpt_take && !recover;
            for (int s = 0; s < N_CKPT; s++) begin
                if (take && int'(ckpt_take_id) == s) begin
                    for (int i = 0; i < N_PREG; i++) begin
                        m_snap[s][i] = nf[i];
                        m_freed[s][i] = 0;
                    end
                end else if (m_valid[s]) begin
                    for (int i = 0; i < N_PREG; i++) m_freed[s][i] = m_freed[s][i] | m_rm[i];
                end
            end
            if (ckpt_release) m_valid[ckpt_release_id] = 0;
            if (recover) begin
                for (int s = 0; s < N_CKPT; s++) if (recover_kill[s]) m_valid[s] = 0;
                m_valid[recover_id] = 0;
            end
            if (take) m_valid[ckpt_take_id] = 1;
            m_count = 0;
            for (int i = 0; i < N_PREG; i++) begin
                m_free[i] = nf[i];
                m_count += int'(nf[i]);
            end
        end
        for (int s = 0; s < N_CKPT; s++) exp_ckv[s] = m_valid[s];
    endtask

    // driver tasks
    task automatic drive_idle();
        alloc_req = '0; retire_valid = '0; retire_idx = '0;
        ckpt_take = 0; ckpt_take_id = '0; ckpt_release = 0; ckpt_release_id = '0;
        recover = 0; recover_id = '0; recover_kill = '0;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        drive_idle();
        reset = 1;
        alloc_req = 2'b11;
        #1;
        n_tests++; if (alloc_valid !== 2'b00) begin n_fail++; $display("FAIL reset_alloc_valid got=%b exp=00", alloc_valid); end
        n_tests++; if (alloc_idx !== '0) begin n_fail++; $display("FAIL reset_alloc_idx got=%h exp=0", alloc_idx); end
        tick();
        drive_idle();
        tick();
        reset = 0;
        n_tests++; if (free_count !== 7'd32) begin n_fail++; $display("FAIL reset_free_count got=%0d exp=32", free_count); end
        n_tests++; if (ckpt_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_ckpt_valid got=%b exp=0000", ckpt_valid); end
    endtask

    task automatic test_basic_alloc();
        alloc_req = 2'b11;
        #1;
        n_tests++; if (alloc_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid got=%b exp=11", alloc_valid); end
        n_tests++; if (alloc_idx !== {6'd33, 6'd32}) begin n_fail++; $display("FAIL basic_idx got=%h exp=%h", alloc_idx, {6'd33, 6'd32}); end
        tick();
        drive_idle();
        n_tests++; if (free_count !== 7'd30) begin n_fail++; $display("FAIL basic_count got=%0d exp=30", free_count); end
    endtask

    task automatic test_exhaust_bypass();
        alloc_req = 2'b11;
        repeat (15) tick();
        drive_idle();
        n_tests++; if (free_count !== 7'd0) begin n_fail++; $display("FAIL exhaust_count got=%0d exp=0", free_count); end
        retire_valid = 2'b01;
        retire_idx   = {6'd0, 6'd5};
        alloc_req    = 2'b01;
        #1;
        n_tests++; if (alloc_valid !== 2'b01) begin n_fail++; $display("FAIL bypass_valid got=%b exp=01", alloc_valid); end
        n_tests++; if (alloc_idx[5:0] !== 6'd5) begin n_fail++; $display("FAIL bypass_idx got=%0d exp=5", alloc_idx[5:0]); end
        tick();
        drive_idle();
        n_tests++; if (free_count !== 7'd0) begin n_fail++; $display("FAIL bypass_count got=%0d exp=0", free_count); end
    endtask

    task automatic test_partial();
        retire_valid = 2'b01;
        retire_idx   = {6'd0, 6'd63};
        tick();
        drive_idle();
        n_tests++; if (free_count !== 7'd1) begin n_fail++; $display("FAIL partial_count got=%0d exp=1", free_count); end
        alloc_req = 2'b11;
        #1;
        n_tests++; if (alloc_valid !== 2'b01) begin n_fail++; $display("FAIL partial_valid11 got=%b exp=01", alloc_valid); end
        n_tests++; if (alloc_idx !== {6'd0, 6'd63}) begin n_fail++; $display("FAIL partial_idx11 got=%h exp=%h", alloc_idx, {6'd0, 6'd63}); end
        alloc_req = 2'b10;
        #1;
        n_tests++; if (alloc_valid !== 2'b10) begin n_fail++; $display("FAIL partial_valid10 got=%b exp=10", alloc_valid); end
        n_tests++; if (alloc_idx !== {6'd63, 6'd0}) begin n_fail++; $display("FAIL partial_idx10 got=%h exp=%h", alloc_idx, {6'd63, 6'd0}); end
        tick();
        drive_idle();
        n_tests++; if (free_count !== 7'd0) begin n_fail++; $display("FAIL partial_count_after got=%0d exp=0", free_count); end
    endtask

    task automatic test_ckpt_recover();
        do_reset();
        alloc_req = 2'b11;
        tick();
        drive_idle();
        ckpt_take = 1; ckpt_take_id = 2'd1;
        tick();
        drive_idle();
        n_tests++; if (ckpt_valid !== 4'b0010) begin n_fail++; $display("FAIL ckpt_take_valid got=%b exp=0010", ckpt_valid); end
        alloc_req = 2'b11;
        repeat (5) tick();
        drive_idle();
        n_tests++; if (free_count !== 7'd20) begin n_fail++; $display("FAIL ckpt_after_alloc got=%0d exp=20", free_count); end
        retire_valid = 2'b01; retire_idx = {6'd0, 6'd40};
        tick();
        retire_idx = {6'd0, 6'd7};
        tick();
        drive_idle();
        n_tests++; if (free_count !== 7'd22) begin n_fail++; $display("FAIL ckpt_after_retire got=%0d exp=22", free_count); end
        recover = 1; recover_id = 2'd1;
        tick();
        drive_idle();
        // snapshot held 34..63; register 7 retired afterwards must survive recovery
        n_tests++; if (free_count !== 7'd31) begin n_fail++; $display("FAIL recover_count got=%0d exp=31", free_count); end
        n_tests++; if (ckpt_valid !== 4'b0000) begin n_fail++; $display("FAIL recover_valid got=%b exp=0000", ckpt_valid); end
        alloc_req = 2'b11;
        #1;
        n_tests++; if (alloc_idx !== {6'd34, 6'd7}) begin n_fail++; $display("FAIL recover_alloc got=%h exp=%h", alloc_idx, {6'd34, 6'd7}); end
        tick();
        drive_idle();
    endtask

    task automatic test_kill();
        do_reset();
        ckpt_take = 1; ckpt_take_id = 2'd0;
        tick();
        ckpt_take_id = 2'd2;
        tick();
        drive_idle();
        n_tests++; if (ckpt_valid !== 4'b0101) begin n_fail++; $display("FAIL kill_pre got=%b exp=0101", ckpt_valid); end
        recover = 1; recover_id = 2'd0; recover_kill = 4'b0100;
        tick();
        drive_idle();
        n_tests++; if (ckpt_valid !== 4'b0000) begin n_fail++; $display("FAIL kill_post got=%b exp=0000", ckpt_valid); end
        ckpt_take = 1; ckpt_take_id = 2'd1;
        tick();
        drive_idle();
        recover = 1; recover_id = 2'd1;
        ckpt_take = 1; ckpt_take_id = 2'd3;
        alloc_req = 2'b11;
        #1;
        n_tests++; if (alloc_valid !== 2'b00) begin n_fail++; $display("FAIL recover_nogrant got=%b exp=00", alloc_valid); end
        tick();
        drive_idle();
        n_tests++; if (ckpt_valid !== 4'b0000) begin n_fail++; $display("FAIL recover_notake got=%b exp=0000", ckpt_valid); end
        n_tests++; if (free_count !== 7'd32) begin n_fail++; $display("FAIL recover_nogrant_count got=%0d exp=32", free_count); end
    endtask

    task automatic test_take_release();
        do_reset();
        ckpt_take = 1; ckpt_take_id = 2'd3;
        ckpt_release = 1; ckpt_release_id = 2'd3;
        tick();
        drive_idle();
        n_tests++; if (ckpt_valid !== 4'b1000) begin n_fail++; $display("FAIL take_wins got=%b exp=1000", ckpt_valid); end
        ckpt_release = 1; ckpt_release_id = 2'd3;
        tick();
        drive_idle();
        n_tests++; if (ckpt_valid !== 4'b0000) begin n_fail++; $display("FAIL release got=%b exp=0000", ckpt_valid); end
    endtask

    task automatic test_mid_reset();
        alloc_req = 2'b11;
        repeat (3) tick();
        ckpt_take = 1; ckpt_take_id = 2'd2;
        tick();
        drive_idle();
        reset = 1;
        alloc_req = 2'b11;
        #1;
        n_tests++; if (alloc_valid !== 2'b00) begin n_fail++; $display("FAIL midreset_valid got=%b exp=00", alloc_valid); end
        tick();
        n_tests++; if (free_count !== 7'd32) begin n_fail++; $display("FAIL midreset_count got=%0d exp=32", free_count); end
        n_tests++; if (ckpt_valid !== 4'b0000) begin n_fail++; $display("FAIL midreset_ckv got=%b exp=0000", ckpt_valid); end
        reset = 0;
        #1;
        n_tests++; if (alloc_idx !== {6'd33, 6'd32}) begin n_fail++; $display("FAIL midreset_alloc got=%h exp=%h", alloc_idx, {6'd33, 6'd32}); end
        tick();
        drive_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int used[$];
            drive_idle();
            alloc_req = 2'($urandom_range(0, 3));
            for (int w = 0; w < WAYS; w++) begin
                if ($urandom_range(0, 2) == 0) begin
                    for (int t = 0; t < 20; t++) begin
                        int r;
                        bit dup;
                        r = $urandom_range(0, N_PREG - 1);
                        dup = 0;
                        foreach (used[k]) if (used[k] == r) dup = 1;
                        if (!m_free[r] && !dup) begin
                            retire_valid[w] = 1'b1;
                            retire_idx[w*PW +: PW] = PW'(r);
                            used.push_back(r);
                            break;
                        end
                    end
                end
            end
            if ($urandom_range(0, 5) == 0) begin
                ckpt_take = 1; ckpt_take_id = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) begin
                ckpt_release = 1; ckpt_release_id = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) begin
                int vs[$];
                for (int s = 0; s < N_CKPT; s++) if (m_valid[s]) vs.push_back(s);
                if (vs.size() > 0) begin
                    recover = 1;
                    recover_id = 2'(vs[$urandom_range(0, vs.size() - 1)]);
                    recover_kill = 4'($urandom_range(0, 15));
                end
            end
            #1;
            model_eval();
            n_tests++; if (alloc_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, alloc_valid, exp_valid); end
            n_tests++; if (alloc_idx !== exp_idx) begin n_fail++; $display("FAIL rand_idx cyc=%0d got=%h exp=%h", cyc, alloc_idx, exp_idx); end
            tick();
            n_tests++; if (free_count !== CNT_W'(m_count)) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, free_count, m_count); end
            n_tests++; if (ckpt_valid !== exp_ckv) begin n_fail++; $display("FAIL rand_ckv cyc=%0d got=%b exp=%b", cyc, ckpt_valid, exp_ckv); end
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_basic_alloc();
        test_exhaust_bypass();
        test_partial();
        test_ckpt_recover();
        test_kill();
        test_take_release();
        test_mid_reset();
        test_random();
        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
